sram_axi_bridge: RTL and testbench

- Downstream neighbour of the CPU core: consumes the core's instruction and data SRAM-style request ports and converts them to a single single-beat AXI4-Lite master port.
- Serialises instruction fetch and data access, and applies fixed kseg0/kseg1 address translation.
- Returns read data plus a stall request that feeds the core's stall controller.

---
 rtl/bridge_pkg.sv | 21 ++
 rtl/addr_xlate.sv | 22 ++
 rtl/sram_axi_bridge.sv | 180 ++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the SRAM-to-AXI4-Lite bridge.
// Holds the FSM encoding, AXI response codes and kseg segment tags.
package bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_D_AR,
    S_D_R,
    S_D_AW,
    S_D_B,
    S_I_AR,
    S_I_R,
    S_DONE
  } state_t;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  localparam logic [2:0] KSEG0 = 3'b100;
  localparam logic [2:0] KSEG1 = 3'b101;

endpackage

// File: rtl/addr_xlate.sv
// Fixed virtual-to-physical mapper: kseg0/kseg1 fold onto
// physical zero, every other segment passes through unchanged.
module addr_xlate
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_vaddr,
  output logic [ADDR_W-1:0] o_paddr
);

  logic [2:0] w_seg;

  assign w_seg = i_vaddr[ADDR_W-1 -: 3];

  always_comb begin
    o_paddr = i_vaddr;
    if (w_seg == KSEG0 || w_seg == KSEG1)
      o_paddr[ADDR_W-1 -: 3] = 3'b000;
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Serialises the core's instruction and data SRAM ports onto
// one single-beat AXI4-Lite master; data wins arbitration.
module sram_axi_bridge
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_sram_en,
  input  logic [DATA_W/8-1:0] inst_sram_wen,
  input  logic [ADDR_W-1:0]   inst_sram_addr,
  output logic [DATA_W-1:0]   inst_sram_rdata,
  input  logic                data_sram_en,
  input  logic [DATA_W/8-1:0] data_sram_wen,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic [DATA_W-1:0]   data_sram_rdata,
  output logic                stallreq,
  output logic                bus_err,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  state_t              r_state;
  logic                r_d_done;
  logic                r_i_done;
  logic [ADDR_W-1:0]   r_araddr;
  logic                r_arvalid;
  logic                r_rready;
  logic [ADDR_W-1:0]   r_awaddr;
  logic                r_awvalid;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_bus_err;
  logic [DATA_W-1:0]   r_inst_rdata;
  logic [DATA_W-1:0]   r_data_rdata;

  logic                w_d_pend;
  logic                w_i_pend;
  logic [ADDR_W-1:0]   w_vaddr;
  logic [ADDR_W-1:0]   w_paddr;
  logic                w_unused;

  assign w_unused = ^inst_sram_wen;

  assign w_d_pend = data_sram_en & ~r_d_done;
  assign w_i_pend = inst_sram_en & ~r_i_done;
  assign stallreq = ~rst & (w_d_pend | w_i_pend);
  assign w_vaddr  = w_d_pend ? data_sram_addr : inst_sram_addr;

  addr_xlate #(.ADDR_W(ADDR_W)) u_xlate (
    .i_vaddr (w_vaddr),
    .o_paddr (w_paddr)
  );

  assign araddr          = r_araddr;
  assign arvalid         = r_arvalid;
  assign rready          = r_rready;
  assign awaddr          = r_awaddr;
  assign awvalid         = r_awvalid;
  assign wdata           = r_wdata;
  assign wstrb           = r_wstrb;
  assign wvalid          = r_wvalid;
  assign bready          = r_bready;
  assign bus_err         = r_bus_err;
  assign inst_sram_rdata = r_inst_rdata;
  assign data_sram_rdata = r_data_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_d_done     <= 1'b0;
      r_i_done     <= 1'b0;
      r_araddr     <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awaddr     <= '0;
      r_awvalid    <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_bus_err    <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      r_bus_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_d_pend && data_sram_wen == '0) begin
            r_araddr  <= w_paddr;
            r_arvalid <= 1'b1;
            r_state   <= S_D_AR;
          end else if (w_d_pend) begin
            r_awaddr  <= w_paddr;
            r_awvalid <= 1'b1;
            r_wdata   <= data_sram_wdata;
            r_wstrb   <= data_sram_wen;
            r_wvalid  <= 1'b1;
            r_state   <= S_D_AW;
          end else if (w_i_pend) begin
            r_araddr  <= w_paddr;
            r_arvalid <= 1'b1;
            r_state   <= S_I_AR;
          end else if (r_d_done || r_i_done) begin
            r_state <= S_DONE;
          end
        end
        S_D_AR, S_I_AR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= (r_state == S_D_AR) ? S_D_R : S_I_R;
          end
        end
        S_D_R: begin
          if (rvalid) begin
            r_rready     <= 1'b0;
            r_data_rdata <= rdata;
            r_d_done     <= 1'b1;
            r_bus_err    <= (rresp != AXI_OKAY);
            r_state      <= w_i_pend ? S_IDLE : S_DONE;
          end
        end
        S_I_R: begin
          if (rvalid) begin
            r_rready     <= 1'b0;
            r_inst_rdata <= rdata;
            r_i_done     <= 1'b1;
            r_bus_err    <= (rresp != AXI_OKAY);
            r_state      <= w_d_pend ? S_IDLE : S_DONE;
          end
        end
        S_D_AW: begin
          // AW and W complete independently, in either order
          if (awready) r_awvalid <= 1'b0;
          if (wready)  r_wvalid  <= 1'b0;
          if ((!r_awvalid || awready) && (!r_wvalid || wready)) begin
            r_bready <= 1'b1;
            r_state  <= S_D_B;
          end
        end
        S_D_B: begin
          if (bvalid) begin
            r_bready  <= 1'b0;
            r_d_done  <= 1'b1;
            r_bus_err <= (bresp != AXI_OKAY);
            r_state   <= w_i_pend ? S_IDLE : S_DONE;
          end
        end
        S_DONE: begin
          r_d_done <= 1'b0;
          r_i_done <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: fetch, load, store,
// error response, async reset and zero-wait back-to-back fetches.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  logic        bus_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int tests_run = 0;
  int tests_failed = 0;
  int ar_cnt = 0;
  int b_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stallreq        (stallreq),
    .bus_err         (bus_err),
    .araddr          (araddr),
    .arvalid         (arvalid),
    .arready         (arready),
    .rdata           (rdata),
    .rresp           (rresp),
    .rvalid          (rvalid),
    .rready          (rready),
    .awaddr          (awaddr),
    .awvalid         (awvalid),
    .awready         (awready),
    .wdata           (wdata),
    .wstrb           (wstrb),
    .wvalid          (wvalid),
    .wready          (wready),
    .bresp           (bresp),
    .bvalid          (bvalid),
    .bready          (bready)
  );

  always @(posedge clk) begin
    if (arvalid && arready) ar_cnt++;
    if (bvalid && bready) b_cnt++;
    if (bus_err) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve_ar(input int wt, output logic [31:0] a,
                          output bit ok);
    ok = 1'b0;
    a  = '0;
    for (int i = 0; i < 50; i++) begin
      if (arvalid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) return;
    repeat (wt) tick();
    a = araddr;
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic serve_r(input int wt, input logic [31:0] d,
                         input logic [1:0] resp);
    repeat (wt) tick();
    rvalid = 1'b1;
    rdata  = d;
    rresp  = resp;
    tick();
    rvalid = 1'b0;
    rresp  = 2'b00;
  endtask

  task automatic test_reset();
    inst_sram_en = 1'b1;
    #1;
    tests_run++;
    if ({arvalid, rready, awvalid, wvalid, bready, stallreq, bus_err}
        !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 0000000",
        {arvalid, rready, awvalid, wvalid, bready, stallreq, bus_err});
    end
    tests_run++;
    if ({inst_sram_rdata, data_sram_rdata} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata: got %h want 0",
        {inst_sram_rdata, data_sram_rdata});
    end
    inst_sram_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if ({arvalid, stallreq} !== 2'b00) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got %b want 00",
        {arvalid, stallreq});
    end
  endtask

  task automatic test_fetch();
    logic [31:0] a;
    bit ok;
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'hBFC0_0000;
    #1;
    tests_run++;
    if (stallreq !== 1'b1) begin
      tests_failed++;
      $display("FAIL fetch_stall_on: got %b want 1", stallreq);
    end
    serve_ar(2, a, ok);
    tests_run++;
    if (!ok || a !== 32'h1FC0_0000) begin
      tests_failed++;
      $display("FAIL fetch_araddr: got %h ok=%0d want 1fc00000", a, ok);
    end
    tests_run++;
    if (stallreq !== 1'b1) begin
      tests_failed++;
      $display("FAIL fetch_stall_mid: got %b want 1", stallreq);
    end
    serve_r(3, 32'h3C1D_0001, 2'b00);
    tests_run++;
    if (stallreq !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_done_stall: got %b want 0", stallreq);
    end
    tests_run++;
    if (inst_sram_rdata !== 32'h3C1D_0001) begin
      tests_failed++;
      $display("FAIL fetch_rdata: got %h want 3c1d0001", inst_sram_rdata);
    end
    inst_sram_en = 1'b0;
    tick();
  endtask

  task automatic test_load_fetch();
    logic [31:0] a;
    bit ok;
    int a0;
    a0 = ar_cnt;
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'b0000;
    data_sram_addr = 32'h8000_1000;
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'hBFC0_0010;
    serve_ar(0, a, ok);
    tests_run++;
    if (!ok || a !== 32'h0000_1000) begin
      tests_failed++;
      $display("FAIL lf_data_araddr: got %h ok=%0d want 00001000", a, ok);
    end
    serve_r(1, 32'h1111_2222, 2'b00);
    tests_run++;
    if (stallreq !== 1'b1 || data_sram_rdata !== 32'h1111_2222) begin
      tests_failed++;
      $display("FAIL lf_data_done: got stall=%b rd=%h want 1 11112222",
        stallreq, data_sram_rdata);
    end
    serve_ar(1, a, ok);
    tests_run++;
    if (!ok || a !== 32'h1FC0_0010) begin
      tests_failed++;
      $display("FAIL lf_inst_araddr: got %h ok=%0d want 1fc00010", a, ok);
    end
    serve_r(0, 32'h3333_4444, 2'b00);
    tests_run++;
    if ({stallreq, inst_sram_rdata, data_sram_rdata}
        !== {1'b0, 32'h3333_4444, 32'h1111_2222}) begin
      tests_failed++;
      $display("FAIL lf_done: got %b %h %h want 0 33334444 11112222",
        stallreq, inst_sram_rdata, data_sram_rdata);
    end
    tick();
    tests_run++;
    if (stallreq !== 1'b1) begin
      tests_failed++;
      $display("FAIL lf_single_done: got %b want 1", stallreq);
    end
    data_sram_en = 1'b0;
    inst_sram_en = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (arvalid !== 1'b0 || ar_cnt - a0 !== 2) begin
      tests_failed++;
      $display("FAIL lf_ar_count: got arvalid=%b n=%0d want 0 2",
        arvalid, ar_cnt - a0);
    end
  endtask

  task automatic test_store();
    int b0;
    bit seen;
    b0 = b_cnt;
    seen = 1'b0;
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'b0011;
    data_sram_wdata = 32'hDEAD_BEEF;
    data_sram_addr  = 32'hA000_2004;
    for (int i = 0; i < 20; i++) begin
      if (awvalid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    tests_run++;
    if (!seen || wvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL st_valids: got aw=%b w=%b want 1 1", awvalid, wvalid);
    end
    tests_run++;
    if ({awaddr, wstrb, wdata} !== {32'h0000_2004, 4'b0011, 32'hDEAD_BEEF})
    begin
      tests_failed++;
      $display("FAIL st_payload: got %h %b %h want 00002004 0011 deadbeef",
        awaddr, wstrb, wdata);
    end
    wready = 1'b1;
    tick();
    wready = 1'b0;
    tests_run++;
    if ({awvalid, wvalid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL st_w_first: got %b want 10", {awvalid, wvalid});
    end
    tick();
    tests_run++;
    if ({awvalid, bready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL st_aw_hold: got %b want 10", {awvalid, bready});
    end
    awready = 1'b1;
    tick();
    awready = 1'b0;
    tests_run++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL st_to_b: got %b want 001", {awvalid, wvalid, bready});
    end
    bvalid = 1'b1;
    bresp  = 2'b00;
    tick();
    bvalid = 1'b0;
    tests_run++;
    if (stallreq !== 1'b0 || bus_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL st_done: got stall=%b err=%b want 0 0",
        stallreq, bus_err);
    end
    data_sram_en  = 1'b0;
    data_sram_wen = 4'b0000;
    repeat (3) tick();
    tests_run++;
    if (b_cnt - b0 !== 1 || bready !== 1'b0) begin
      tests_failed++;
      $display("FAIL st_b_once: got n=%0d bready=%b want 1 0",
        b_cnt - b0, bready);
    end
  endtask

  task automatic test_error();
    logic [31:0] a;
    bit ok;
    int e0;
    e0 = err_cnt;
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'b0000;
    data_sram_addr = 32'h8000_0040;
    serve_ar(0, a, ok);
    tests_run++;
    if (!ok || a !== 32'h0000_0040) begin
      tests_failed++;
      $display("FAIL err_araddr: got %h ok=%0d want 00000040", a, ok);
    end
    serve_r(2, 32'hCAFE_F00D, 2'b10);
    tests_run++;
    if ({bus_err, stallreq, data_sram_rdata}
        !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
      tests_failed++;
      $display("FAIL err_done: got %b %b %h want 1 0 cafef00d",
        bus_err, stallreq, data_sram_rdata);
    end
    data_sram_en = 1'b0;
    tick();
    tests_run++;
    if (bus_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_pulse_end: got %b want 0", bus_err);
    end
    tick();
    tests_run++;
    if (err_cnt - e0 !== 1) begin
      tests_failed++;
      $display("FAIL err_once: got %0d want 1", err_cnt - e0);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] a;
    bit ok;
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'b0000;
    data_sram_addr = 32'h9FC0_0100;
    serve_ar(0, a, ok);
    tests_run++;
    if (!ok || a !== 32'h1FC0_0100 || rready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ar_in_dr: got %h rready=%b want 1fc00100 1",
        a, rready);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({arvalid, rready, awvalid, wvalid, bready, stallreq}
        !== 6'b0) begin
      tests_failed++;
      $display("FAIL ar_ctrl_zero: got %b want 000000",
        {arvalid, rready, awvalid, wvalid, bready, stallreq});
    end
    tests_run++;
    if ({inst_sram_rdata, data_sram_rdata} !== 64'h0) begin
      tests_failed++;
      $display("FAIL ar_rdata_zero: got %h want 0",
        {inst_sram_rdata, data_sram_rdata});
    end
    data_sram_en = 1'b0;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    tests_run++;
    if ({arvalid, rready, stallreq} !== 3'b000) begin
      tests_failed++;
      $display("FAIL ar_idle_after: got %b want 000",
        {arvalid, rready, stallreq});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr;
    logic [31:0] val;
    int a0;
    a0 = ar_cnt;
    arready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = 32'h0040_0000 + 32'(4 * i);
      val  = 32'h5A00_0000 + 32'(i);
      inst_sram_en   = 1'b1;
      inst_sram_addr = addr;
      tick();
      tests_run++;
      if (arvalid !== 1'b1 || araddr !== addr) begin
        tests_failed++;
        $display("FAIL b2b_ar%0d: got %b %h want 1 %h",
          i, arvalid, araddr, addr);
      end
      tick();
      tests_run++;
      if ({arvalid, rready} !== 2'b01) begin
        tests_failed++;
        $display("FAIL b2b_r%0d: got %b want 01", i, {arvalid, rready});
      end
      rvalid = 1'b1;
      rdata  = val;
      tick();
      rvalid = 1'b0;
      tests_run++;
      if (stallreq !== 1'b0 || inst_sram_rdata !== val) begin
        tests_failed++;
        $display("FAIL b2b_done%0d: got %b %h want 0 %h",
          i, stallreq, inst_sram_rdata, val);
      end
      inst_sram_en = 1'b0;
      tick();
    end
    arready = 1'b0;
    tests_run++;
    if (ar_cnt - a0 !== 3) begin
      tests_failed++;
      $display("FAIL b2b_ar_count: got %0d want 3", ar_cnt - a0);
    end
  endtask

  initial begin
    rst             = 1'b1;
    inst_sram_en    = 1'b0;
    inst_sram_wen   = 4'b0000;
    inst_sram_addr  = '0;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    arready         = 1'b0;
    rdata           = '0;
    rresp           = 2'b00;
    rvalid          = 1'b0;
    awready         = 1'b0;
    wready          = 1'b0;
    bresp           = 2'b00;
    bvalid          = 1'b0;
    test_reset();
    test_fetch();
    test_load_fetch();
    test_store();
    test_error();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
